// File: rtl/nnrv_exec_mdu.sv
// Execute stage: single-cycle ALU/JMP plus iterative RV32/64 M-extension
// multiply/divide, one bit per cycle, with valid/ready handshake and flush.
module nnrv_exec_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic [4:0]      i_exec_type,
    input  logic [4:0]      i_rd,
    input  logic            i_rd_en,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_rd_en,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_rd_reg,
    output logic            o_busy
);

    localparam logic [4:0] OP_ADD    = 5'h01;
    localparam logic [4:0] OP_SUB    = 5'h02;
    localparam logic [4:0] OP_SLT    = 5'h03;
    localparam logic [4:0] OP_SLTU   = 5'h04;
    localparam logic [4:0] OP_XOR    = 5'h05;
    localparam logic [4:0] OP_OR     = 5'h06;
    localparam logic [4:0] OP_AND    = 5'h07;
    localparam logic [4:0] OP_SLL    = 5'h08;
    localparam logic [4:0] OP_SRL    = 5'h09;
    localparam logic [4:0] OP_SRA    = 5'h0A;
    localparam logic [4:0] OP_JMP    = 5'h0B;
    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12;
    localparam logic [4:0] OP_MULHU  = 5'h13;
    localparam logic [4:0] OP_DIV    = 5'h14;
    localparam logic [4:0] OP_DIVU   = 5'h15;
    localparam logic [4:0] OP_REM    = 5'h16;
    localparam logic [4:0] OP_REMU   = 5'h17;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
    state_t state, state_nx;

    logic [XLEN-1:0]   hi, lo, mcand, hi_nx, lo_nx;
    logic [SHW-1:0]    cnt;
    logic [4:0]        op_q;
    logic              neg_q, neg_r;

    logic              accept, is_mul, is_div, known, iterative, done;
    logic              op1_signed, op2_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, quick_res, iter_res;
    logic [SHW-1:0]    shamt;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] prod;

    assign o_ready = i_rst_n && (state == IDLE) && (!o_valid || i_ready) && !i_flush;
    assign o_busy  = (state == CALC);
    assign accept  = i_valid && o_ready;
    assign shamt   = i_op2[SHW-1:0];

    assign is_mul     = i_exec_type inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    assign is_div     = i_exec_type inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign known      = i_exec_type inside {[OP_ADD:OP_JMP], [OP_MUL:OP_REMU]};
    assign op1_signed = i_exec_type inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign op2_signed = i_exec_type inside {OP_MULH, OP_DIV, OP_REM};
    assign a_neg      = op1_signed && i_op1[XLEN-1];
    assign b_neg      = op2_signed && i_op2[XLEN-1];
    assign a_mag      = a_neg ? -i_op1 : i_op1;
    assign b_mag      = b_neg ? -i_op2 : i_op2;
    assign div_zero   = is_div && (i_op2 == '0);
    assign div_ovf    = (i_exec_type inside {OP_DIV, OP_REM}) &&
                        (i_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_op2 == '1);
    assign iterative  = is_mul || (is_div && !div_zero && !div_ovf);
    assign done       = (cnt == SHW'(XLEN-1));

    always_comb begin
        quick_res = '0;
        case (i_exec_type)
            OP_ADD:  quick_res = i_op1 + i_op2;
            OP_SUB:  quick_res = i_op1 - i_op2;
            OP_SLT:  quick_res = {{(XLEN-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
            OP_SLTU: quick_res = {{(XLEN-1){1'b0}}, (i_op1 < i_op2)};
            OP_XOR:  quick_res = i_op1 ^ i_op2;
            OP_OR:   quick_res = i_op1 | i_op2;
            OP_AND:  quick_res = i_op1 & i_op2;
            OP_SLL:  quick_res = i_op1 << shamt;
            OP_SRL:  quick_res = i_op1 >> shamt;
            OP_SRA:  quick_res = XLEN'($signed(i_op1) >>> shamt);
            OP_JMP:  quick_res = i_pc + XLEN'(4);
            // only the short-circuit divide cases reach the result register from here
            OP_DIV, OP_DIVU: quick_res = div_zero ? '1 : i_op1;
            OP_REM, OP_REMU: quick_res = div_zero ? i_op1 : '0;
            default: quick_res = '0;
        endcase
    end

    // {hi,lo}: multiply shifts the product right past the multiplier in lo;
    // divide shifts the dividend out of lo into the partial remainder in hi.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        div_trial = {hi, lo[XLEN-1]} - {1'b0, mcand};
        if (op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) begin
            hi_nx = mul_sum[XLEN:1];
            lo_nx = {mul_sum[0], lo[XLEN-1:1]};
        end else if (!div_trial[XLEN]) begin
            hi_nx = div_trial[XLEN-1:0];
            lo_nx = {lo[XLEN-2:0], 1'b1};
        end else begin
            hi_nx = {hi[XLEN-2:0], lo[XLEN-1]};
            lo_nx = {lo[XLEN-2:0], 1'b0};
        end
        prod = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
        case (op_q)
            OP_MUL:                       iter_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: iter_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              iter_res = neg_q ? -lo_nx : lo_nx;
            default:                      iter_res = neg_r ? -hi_nx : hi_nx;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (i_flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept)                 state_nx = iterative ? CALC : IDLE;
                    else if (o_valid && !i_ready) state_nx = HOLD;
                end
                CALC:    if (done)    state_nx = IDLE;
                HOLD:    if (i_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid  <= 1'b0;
            o_rd_en  <= 1'b0;
            o_rd     <= '0;
            o_rd_reg <= '0;
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            cnt      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_rd    <= i_rd;
                        o_rd_en <= i_rd_en && known;
                        op_q    <= i_exec_type;
                        cnt     <= '0;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        hi      <= '0;
                        lo      <= is_mul ? b_mag : a_mag;
                        mcand   <= is_mul ? a_mag : b_mag;
                        o_valid <= !iterative;
                        if (!iterative) o_rd_reg <= quick_res;
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                    end
                end
                CALC: begin
                    hi  <= hi_nx;
                    lo  <= lo_nx;
                    cnt <= cnt + SHW'(1);
                    if (done) begin
                        o_valid  <= 1'b1;
                        o_rd_reg <= iter_res;
                    end
                end
                HOLD:    if (i_ready) o_valid <= 1'b0;
                default: o_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/nnrv_exec_mdu.md
NNRV_EXEC_MDU -- requirements
Module: nnrv_exec_mdu

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, as the datapath width; legal values are 32 and 64.
REQ-002 The block SHALL take parameter SHW, default $clog2(XLEN), as the shift-amount width.
REQ-003 i_clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 i_valid  input  1  upstream operation valid.
REQ-006 o_ready  output  1  block can accept an operation this cycle.
REQ-007 i_op1, i_op2  input  XLEN each  operands.
REQ-008 i_exec_type  input  5  operation code (REQ-013).
REQ-009 i_rd  input  5  destination register; i_rd_en  input  1  writeback enable.
REQ-010 i_pc  input  XLEN  PC of the operation.
REQ-011 i_flush  input  1  abort in-flight and pending work.
REQ-012 The block SHALL drive these outputs:
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_rd_en  output  1  writeback enable.
- o_rd  output  5  destination register.
- o_rd_reg  output  XLEN  result.
- o_busy  output  1  iterative operation in progress.

Function
REQ-013 Opcodes SHALL be:
- 0x01 ADD, 0x02 SUB, 0x03 SLT, 0x04 SLTU, 0x05 XOR, 0x06 OR, 0x07 AND, 0x08 SLL, 0x09 SRL, 0x0A SRA, 0x0B JMP (result pc+4).
- 0x10 MUL, 0x11 MULH, 0x12 MULHSU, 0x13 MULHU, 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU, with RISC-V M-extension semantics.
REQ-014 Shift amount SHALL be i_op2[SHW-1:0]; upper bits of i_op2 SHALL be ignored.
REQ-015 An operation SHALL be accepted on a rising edge where i_valid && o_ready && !i_flush.
REQ-016 o_ready SHALL equal (state==IDLE) && (!o_valid || i_ready) && !i_flush.
REQ-017 The FSM SHALL have three states:
- IDLE: accepts operations.
- CALC: iterating a MUL or DIV operation.
- HOLD: result presented and waiting for i_ready.
REQ-018 ALU, JMP, unknown-opcode, divide-by-zero and DIV-overflow operations SHALL have 1-cycle latency: o_valid=1 after the accepting edge.
REQ-019 Each MUL-class and DIV-class operation SHALL iterate 1 bit per cycle in CALC, for exactly XLEN cycles.
REQ-020 o_valid SHALL rise XLEN+1 edges after acceptance of a MUL-class or DIV-class operation, and o_busy SHALL be 1 throughout CALC.
REQ-021 Multiply SHALL use a 2*XLEN shift-add accumulator with sign correction for MULH/MULHSU; the operands SHALL be converted to magnitudes and the signs fixed up at completion.
REQ-022 Divide SHALL be restoring division on magnitudes; the quotient sign SHALL be op1^op2 and the remainder sign SHALL be that of op1.
REQ-023 Divide by zero SHALL return quotient all-ones and remainder op1.
REQ-024 DIV with op1 = most-negative and op2 = -1 SHALL return quotient op1 and remainder 0.
REQ-025 An unknown opcode SHALL return o_rd_reg=0 and o_rd_en=0.
REQ-026 o_rd, o_rd_en and o_rd_reg SHALL be registered at acceptance or at completion, and SHALL hold stable while o_valid && !i_ready.
REQ-027 On a completion edge with i_ready=1 and a new i_valid, the block SHALL accept the back-to-back operation without a bubble.
REQ-028 i_flush SHALL, on the next edge, clear o_valid and o_busy and force the FSM to IDLE; a flush in the same cycle as i_valid SHALL win, and the operation SHALL NOT be accepted.
REQ-029 Operand inputs SHALL be ignored while in CALC; values are latched at acceptance.

Reset
REQ-030 When i_rst_n=0, the block SHALL immediately force: FSM to IDLE; o_valid, o_busy, o_rd_en, o_rd and o_rd_reg to 0; accumulators to 0.
REQ-031 o_ready SHALL be 0 while i_rst_n=0, and SHALL be 1 on the first cycle after deassertion.
REQ-032 Reset asserted during CALC SHALL discard the operation, and no o_valid SHALL follow.

Verification
REQ-033 XLEN=32, ADD 0x7FFFFFFF+1, i_ready=1 -> o_valid after 1 edge, o_rd_reg=0x80000000.
REQ-034 SLL op1=1, op2=0x21 -> 0x00000002 (shift masked to 1).
REQ-035 MULH op1=0x80000000, op2=0x80000000 -> o_busy for 32 cycles, o_valid at edge 33, o_rd_reg=0x40000000.
REQ-036 DIV op1=-7, op2=2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU op2=0 -> 0xFFFFFFFF in 1 cycle.
REQ-037 DIVU in CALC at cycle 10 with i_flush=1 -> IDLE next edge, no o_valid; i_ready=0 for 5 cycles after an ADD result -> o_valid held, o_rd_reg stable, o_ready=0.
REQ-038 i_rst_n pulsed low mid-MUL -> outputs 0 immediately, no result produced; the next ADD completes normally.
